// File: rtl/tt_sweep_ctrl.sv
// Truth-table sweep controller: steps a 3-input gate through all eight input
// combinations, samples its output and compares against a programmed table.
module tt_sweep_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned CNT_W         = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cfg_we,
  input  logic [7:0] cfg_tt,
  input  logic       start,
  output logic [2:0] dut_in,
  input  logic       dut_out,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] exp_tt,
  output logic [7:0] observed_tt,
  output logic [7:0] mismatch
);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    DONE
  } state_e;

  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(SETTLE_CYCLES - 1);

  state_e           state_q, state_d;
  logic [2:0]       idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic [7:0]       exp_q, exp_d;
  logic [7:0]       obs_q, obs_d;
  logic [7:0]       mis_q, mis_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      exp_q   <= '0;
      obs_q   <= '0;
      mis_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      exp_q   <= exp_d;
      obs_q   <= obs_d;
      mis_q   <= mis_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = SETTLE;
      SETTLE:  if ((cnt_q == '0) && (idx_q == 3'd7)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The first IDLE cycle after DONE carries the done pulse with busy still high;
  // busy only drops on the following edge unless a held start re-arms it.
  always_comb begin
    idx_d  = idx_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    done_d = 1'b0;
    pass_d = pass_q;
    exp_d  = exp_q;
    obs_d  = obs_q;
    mis_d  = mis_q;
    unique case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (cfg_we) exp_d = cfg_tt;
        if (start) begin
          idx_d  = '0;
          cnt_d  = CNT_RELOAD;
          obs_d  = '0;
          mis_d  = '0;
          pass_d = 1'b0;
          busy_d = 1'b1;
        end
      end
      SETTLE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          obs_d[3'd7 - idx_q] = dut_out;
          if (idx_q != 3'd7) begin
            idx_d = idx_q + 3'd1;
            cnt_d = CNT_RELOAD;
          end
        end
      end
      DONE: begin
        mis_d  = obs_q ^ exp_q;
        pass_d = (obs_q == exp_q);
        done_d = 1'b1;
      end
      default: ;
    endcase
  end

  // The sweep index is the gate drive itself.
  always_comb begin
    dut_in      = idx_q;
    busy        = busy_q;
    done        = done_q;
    pass        = pass_q;
    exp_tt      = exp_q;
    observed_tt = obs_q;
    mismatch    = mis_q;
  end

endmodule

// File: tb/tb_tt_sweep_ctrl.sv
// Randomized scoreboard bench for tt_sweep_ctrl with a behavioural gate and
// a cycle-level reference model of sweep timing and results.
module tb_tt_sweep_ctrl;

  localparam int S     = 4;
  localparam int SWEEP = 8 * S;

  logic       clk     = 1'b0;
  logic       rst_n   = 1'b1;
  logic       cfg_we  = 1'b0;
  logic       start   = 1'b0;
  logic [7:0] cfg_tt  = '0;
  logic [7:0] gate_tt = '0;
  logic [2:0] dut_in;
  logic       dut_out;
  logic       busy, done, pass;
  logic [7:0] exp_tt, observed_tt, mismatch;

  tt_sweep_ctrl #(.SETTLE_CYCLES(S), .CNT_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_we     (cfg_we),
    .cfg_tt     (cfg_tt),
    .start      (start),
    .dut_in     (dut_in),
    .dut_out    (dut_out),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .exp_tt     (exp_tt),
    .observed_tt(observed_tt),
    .mismatch   (mismatch)
  );

  // Behavioural gate: truth table bit (7-i) is the output for input combo i.
  assign dut_out = gate_tt[3'd7 - dut_in];

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
  endtask

  typedef struct {
    logic [7:0] obs;
    logic [7:0] mis;
    logic       pas;
    int         dc;
  } res_t;

  res_t       sb[$];
  res_t       cur;
  int         cyc    = 0;
  bit         m_act  = 1'b0;
  int         m_t0   = 0;
  logic [7:0] m_exp  = '0;
  logic [7:0] m_mis  = '0;
  logic       m_pass = 1'b0;

  // Reference model: a sweep accepted at edge t0 occupies edges t0..t0+SWEEP+1,
  // its result is simply the gate's truth table against the expected table.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_act  = 1'b0;
      m_exp  = '0;
      m_mis  = '0;
      m_pass = 1'b0;
      sb.delete();
    end else begin
      cyc++;
      if (m_act && cyc == m_t0 + SWEEP + 1) begin
        m_pass = cur.pas;
        m_mis  = cur.mis;
      end
      if (!m_act || cyc >= m_t0 + SWEEP + 2) begin
        if (cfg_we) m_exp = cfg_tt;
        if (start) begin
          m_act  = 1'b1;
          m_t0   = cyc;
          cur    = '{obs: gate_tt, mis: gate_tt ^ m_exp, pas: (gate_tt == m_exp), dc: cyc + SWEEP + 1};
          sb.push_back(cur);
          m_pass = 1'b0;
          m_mis  = '0;
        end
      end
    end
  end

  // Monitor: compares DUT outputs against the model every falling edge.
  always @(negedge clk) begin
    if (rst_n) begin
      int   k;
      logic [2:0] want_in;
      res_t e;
      k       = cyc - m_t0;
      want_in = !m_act ? 3'd0 : (k < SWEEP ? 3'(k / S) : 3'd7);
      chk("exp_tt", exp_tt, m_exp);
      chk("busy", busy, (m_act && k >= 0 && k <= SWEEP + 1));
      chk("dut_in", dut_in, want_in);
      chk("pass_hold", pass, m_pass);
      chk("mismatch_hold", mismatch, m_mis);
      if (done === 1'b1 || (sb.size() > 0 && sb[0].dc == cyc)) begin
        if (sb.size() == 0) begin
          chk("done_spurious", done, 0);
        end else begin
          e = sb.pop_front();
          chk("done_pulse", done, 1);
          chk("done_cycle", cyc, e.dc);
          chk("observed_tt", observed_tt, e.obs);
          chk("mismatch", mismatch, e.mis);
          chk("pass", pass, e.pas);
        end
      end
    end
  end

  task automatic reset_checks();
    chk("rst_dut_in", dut_in, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_exp_tt", exp_tt, 0);
    chk("rst_observed_tt", observed_tt, 0);
    chk("rst_mismatch", mismatch, 0);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (busy === 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("busy_drop", busy, 0);
  endtask

  task automatic launch(input logic [7:0] g, input logic [7:0] c, input logic we);
    @(negedge clk);
    gate_tt = g;
    cfg_we  = we;
    cfg_tt  = c;
    start   = 1'b1;
    @(negedge clk);
    cfg_we = 1'b0;
    start  = 1'b0;
  endtask

  initial begin
    logic [7:0] g, c;
    #2 rst_n = 1'b0;
    #1 reset_checks();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    // AND3 against 8'h01: pass.
    launch(8'h01, 8'h01, 1'b1);
    wait_idle();

    // OR3 against 8'h01: fail with 8'h7E mismatch.
    launch(8'h7F, 8'h00, 1'b0);
    wait_idle();

    // start and cfg_we mid-sweep must be ignored.
    launch(8'h01, 8'h00, 1'b0);
    repeat (8) @(negedge clk);
    start  = 1'b1;
    cfg_we = 1'b1;
    cfg_tt = 8'hFF;
    @(negedge clk);
    start  = 1'b0;
    cfg_we = 1'b0;
    wait_idle();

    // Reset in the middle of a sweep, then a fresh sweep.
    launch(8'h01, 8'h00, 1'b0);
    repeat (11) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 reset_checks();
    @(posedge clk);
    #2 rst_n = 1'b1;
    launch(8'h01, 8'h01, 1'b1);
    wait_idle();

    // NAND3 with same-cycle configure and start, start held for back-to-back sweeps.
    @(negedge clk);
    gate_tt = 8'hFE;
    cfg_we  = 1'b1;
    cfg_tt  = 8'hFE;
    start   = 1'b1;
    @(negedge clk);
    cfg_we = 1'b0;
    repeat (2 * (SWEEP + 2) + 3) @(negedge clk);
    start = 1'b0;
    wait_idle();

    // Randomized gates/tables with junk requests early in each sweep.
    for (int i = 0; i < 12; i++) begin
      g = 8'($urandom);
      c = ($urandom_range(0, 1) == 1) ? g : 8'($urandom);
      launch(g, c, 1'b1);
      for (int j = 0; j < 14; j++) begin
        @(negedge clk);
        start  = 1'($urandom_range(0, 1));
        cfg_we = 1'($urandom_range(0, 1));
        cfg_tt = 8'($urandom);
      end
      @(negedge clk);
      start  = 1'b0;
      cfg_we = 1'b0;
      wait_idle();
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
